// File: rtl/uart_frame_rx.sv
// Receive-side deframer: SOF, LEN, payload, CHK (XOR of LEN and payload) -> verified payload stream.
// Optional UART_FRAME_STATS_EN adds saturating good/bad frame counters.
module uart_frame_rx #(
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_m_valid,
  output logic [7:0]  o_m_data,
  output logic        o_m_last,
  input  logic        i_m_ready,
  output logic [7:0]  o_frame_len,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0] o_frames_ok,
  output logic [15:0] o_frames_err
`endif
);

  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;
  typedef enum logic [1:0] {E_LEN = 2'd0, E_CHK = 2'd1, E_TMO = 2'd2, E_OVR = 2'd3} err_code_t;

  state_t      state_q, state_n;
  err_code_t   code_n;
  logic        err_n;
  logic [7:0]  len_q;
  logic [7:0]  chk_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] tcnt;
  logic [7:0]  mem [2**AW];
  logic        timeout_hit;
  logic        handshake;
  logic        rd_last;

  assign timeout_hit = (tcnt == TW'(TIMEOUT_CLKS - 1));
  assign o_m_valid   = (state_q == S_DRAIN);
  assign handshake   = o_m_valid && i_m_ready;
  assign rd_last     = (8'(rd_idx) == (len_q - 8'd1));
  assign o_m_data    = o_m_valid ? mem[rd_idx[AW-1:0]] : '0;
  assign o_m_last    = o_m_valid && rd_last;
  assign o_frame_len = len_q;
  assign o_busy      = (state_q != S_IDLE);

  always_comb begin
    state_n = state_q;
    err_n   = 1'b0;
    code_n  = E_LEN;
    unique case (state_q)
      S_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SOF_BYTE)) state_n = S_LEN;
      end
      S_LEN: begin
        if (i_rx_dv) begin
          if ((i_rx_byte == 8'd0) || (32'(i_rx_byte) > MAX_LEN)) begin
            err_n   = 1'b1;
            code_n  = E_LEN;
            state_n = S_IDLE;
          end else begin
            state_n = S_PAYLOAD;
          end
        end else if (timeout_hit) begin
          err_n   = 1'b1;
          code_n  = E_TMO;
          state_n = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (i_rx_dv) begin
          if ((8'(wr_idx) + 8'd1) == len_q) state_n = S_CHK;
        end else if (timeout_hit) begin
          err_n   = 1'b1;
          code_n  = E_TMO;
          state_n = S_IDLE;
        end
      end
      S_CHK: begin
        if (i_rx_dv) begin
          if (i_rx_byte == chk_q) begin
            state_n = S_DRAIN;
          end else begin
            err_n   = 1'b1;
            code_n  = E_CHK;
            state_n = S_IDLE;
          end
        end else if (timeout_hit) begin
          err_n   = 1'b1;
          code_n  = E_TMO;
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Strobes here are dropped as overruns, even one coinciding with the final handshake.
        if (i_rx_dv) begin
          err_n  = 1'b1;
          code_n = E_OVR;
        end
        if (handshake && rd_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      chk_q      <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      tcnt       <= '0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      state_q    <= state_n;
      o_err      <= err_n;
      o_err_code <= err_n ? code_n : '0;

      if ((state_q inside {S_LEN, S_PAYLOAD, S_CHK}) && !i_rx_dv && !timeout_hit)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      unique case (state_q)
        S_LEN: begin
          if (i_rx_dv) begin
            len_q  <= i_rx_byte;
            chk_q  <= i_rx_byte;
            wr_idx <= '0;
          end
        end
        S_PAYLOAD: begin
          if (i_rx_dv) begin
            chk_q  <= chk_q ^ i_rx_byte;
            wr_idx <= wr_idx + 1'b1;
          end
        end
        S_CHK: begin
          if (i_rx_dv) rd_idx <= '0;
        end
        S_DRAIN: begin
          if (handshake) rd_idx <= rd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state_q == S_PAYLOAD) && i_rx_dv && !i_rst) mem[wr_idx[AW-1:0]] <= i_rx_byte;
  end

`ifdef UART_FRAME_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frames_ok  <= '0;
      o_frames_err <= '0;
    end else begin
      if ((state_q == S_CHK) && (state_n == S_DRAIN) && (o_frames_ok != '1))
        o_frames_ok <= o_frames_ok + 1'b1;
      if (o_err && (o_frames_err != '1))
        o_frames_err <= o_frames_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized bench for uart_frame_rx against a frame-level queue model, plus directed literal checks.
module tb_uart_frame_rx;

  localparam int TMO  = 40;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] rx = '0;
  logic       ready = 1'b1;
  logic       m_valid, m_last, err, busy;
  logic [7:0] m_data, flen;
  logic [1:0] err_code;
`ifdef UART_FRAME_STATS_EN
  logic [15:0] frames_ok, frames_err;
`endif

  uart_frame_rx #(.SOF_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_dv(dv), .i_rx_byte(rx),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_last(m_last), .i_m_ready(ready),
    .o_frame_len(flen), .o_err(err), .o_err_code(err_code), .o_busy(busy)
`ifdef UART_FRAME_STATS_EN
    , .o_frames_ok(frames_ok), .o_frames_err(frames_err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 hunting SOF, 1 want LEN, 2 collecting payload, 3 want CHK, 4 releasing payload
  int         mode = 0;
  int         want_len = 0;
  int         silent = 0;
  logic [7:0] frm[$];
  logic [7:0] outq[$];
  logic [7:0] e_flen = 0;
  logic       e_err = 0;
  logic [1:0] e_code = 0;
  int         s_ok = 0, s_err = 0;

  always @(posedge clk) begin
    logic [7:0] x;
    if (rst) begin
      mode = 0; silent = 0; frm.delete(); outq.delete();
      e_flen = 0; e_err = 0; e_code = 0; s_ok = 0; s_err = 0;
    end else begin
      if (e_err && s_err < 65535) s_err++;
      e_err = 0;
      if (mode inside {1, 2, 3} && !dv) begin
        silent++;
        if (silent == TMO) begin e_err = 1; e_code = 2; mode = 0; end
      end else begin
        silent = 0;
        case (mode)
          0: if (dv && rx == 8'hA5) mode = 1;
          1: if (dv) begin
               e_flen = rx;
               if (rx == 0 || rx > MAXL) begin e_err = 1; e_code = 0; mode = 0; end
               else begin want_len = rx; frm.delete(); mode = 2; end
             end
          2: if (dv) begin
               frm.push_back(rx);
               if (frm.size() == want_len) mode = 3;
             end
          3: if (dv) begin
               x = 8'(want_len);
               foreach (frm[i]) x ^= frm[i];
               if (x == rx) begin
                 outq = frm; mode = 4;
                 if (s_ok < 65535) s_ok++;
               end else begin e_err = 1; e_code = 1; mode = 0; end
             end
          4: begin
               if (dv) begin e_err = 1; e_code = 3; end
               if (ready) begin
                 void'(outq.pop_front());
                 if (outq.size() == 0) mode = 0;
               end
             end
          default: mode = 0;
        endcase
      end
    end
  end

  // ---------------- compare + capture ----------------
  logic [8:0] got[$];
  logic [1:0] errs[$];

  always @(negedge clk) begin
    check("busy", busy, mode != 0);
    check("valid", m_valid, mode == 4);
    if (mode == 4) begin
      check("data", m_data, outq[0]);
      check("last", m_last, outq.size() == 1);
      check("frame_len", flen, e_flen);
    end
    check("err", err, e_err);
    if (e_err) check("err_code", err_code, e_code);
`ifdef UART_FRAME_STATS_EN
    check("frames_ok", frames_ok, s_ok);
    check("frames_err", frames_err, s_err);
`endif
    if (m_valid && ready) got.push_back({m_last, m_data});
    if (err) errs.push_back(err_code);
  end

  // ---------------- stimulus ----------------
  bit rnd_rdy = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_rdy) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] b);
    dv = 1'b1; rx = b; tick(); dv = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (n >= 2000) check("idle_timeout", 1, 0);
    repeat (2) tick();
  endtask

  task automatic check_good3(input string tag);
    check({tag, "_count"}, got.size(), 3);
    if (got.size() == 3) begin
      check({tag, "_b0"}, got[0], 9'h011);
      check({tag, "_b1"}, got[1], 9'h022);
      check({tag, "_b2"}, got[2], 9'h133);
    end
  endtask

  task automatic send_good3();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
  endtask

  task automatic random_frame();
    int kind, len, k;
    logic [7:0] c, b;
    kind = $urandom_range(0, 9);
    len = $urandom_range(1, MAXL);
    if (kind == 3) begin
      repeat ($urandom_range(1, 4)) begin
        b = 8'($urandom_range(0, 255));
        send(b == 8'hA5 ? 8'h5A : b);
      end
      return;
    end
    send(8'hA5);
    repeat ($urandom_range(0, 3)) tick();
    if (kind == 0) begin
      send(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
      return;
    end
    send(8'(len));
    c = 8'(len);
    k = (kind == 2) ? $urandom_range(0, len - 1) : len;
    for (int i = 0; i < k; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      b = 8'($urandom_range(0, 255));
      c ^= b;
      send(b);
    end
    if (kind == 2) begin
      repeat (TMO + 2) tick();
      return;
    end
    if ($urandom_range(0, 7) == 0) repeat (TMO - 2) tick();
    if (kind == 1) c ^= 8'(1 << $urandom_range(0, 7));
    send(c);
    if (kind == 5) send(8'($urandom_range(0, 255)));
  endtask

  initial begin
    tick(); tick();
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_flen", flen, 0);
    rst = 1'b0;
    tick();

    // Good frame, always ready
    got.delete(); errs.delete();
    ready = 1'b1;
    send_good3();
    wait_idle();
    check_good3("good");
    check("good_noerr", errs.size(), 0);

    // Backpressure: ready toggles each cycle
    got.delete();
    send_good3();
    for (int i = 0; i < 10; i++) begin ready = ~ready; tick(); end
    ready = 1'b1;
    wait_idle();
    check_good3("bp");

    // Bad checksum 02^AA^BB = 13 != 00
    errs.delete(); got.delete();
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    wait_idle();
    check("badchk_n", errs.size(), 1);
    if (errs.size() == 1) check("badchk_code", errs[0], 1);
    check("badchk_nodata", got.size(), 0);
`ifdef UART_FRAME_STATS_EN
    check("stats_ok_lit", frames_ok, 2);
    check("stats_err_lit", frames_err, 1);
`endif

    // LEN 0 and LEN 17
    errs.delete();
    send(8'hA5); send(8'h00); wait_idle();
    send(8'hA5); send(8'h11); wait_idle();
    check("badlen_n", errs.size(), 2);
    if (errs.size() == 2) begin
      check("len0_code", errs[0], 0);
      check("len17_code", errs[1], 0);
    end

    // Timeout then good frame
    errs.delete(); got.delete();
    send(8'hA5); send(8'h02); send(8'h55);
    repeat (TMO + 2) tick();
    check("tmo_busy", busy, 0);
    send_good3();
    wait_idle();
    check("tmo_n", errs.size(), 1);
    if (errs.size() == 1) check("tmo_code", errs[0], 2);
    check_good3("after_tmo");

    // Back-to-back: SOF on final handshake is an overrun
    errs.delete();
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F); send(8'hA5);
    wait_idle();
    check("b2b_n", errs.size(), 1);
    if (errs.size() == 1) check("b2b_code", errs[0], 3);

    // Overrun under backpressure, then reset mid-drain
    errs.delete(); got.delete();
    ready = 1'b0;
    send_good3();
    send(8'hA5);
    tick(); tick();
    check("ovr_n", errs.size(), 1);
    if (errs.size() == 1) check("ovr_code", errs[0], 3);
    check("ovr_hold_data", m_data, 8'h11);
    check("ovr_hold_valid", m_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_flen", flen, 0);
    check("mid_rst_err", err, 0);
    ready = 1'b1;
    tick();

    // Randomized traffic
    rnd_rdy = 1;
    for (int f = 0; f < 200; f++) begin
      random_frame();
      wait_idle();
    end
    rnd_rdy = 0;
    ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
